vga_text_reader: RTL
====================

VGA_TEXT_READER -- requirements
Module: vga_text_reader

Interface
REQ-001 Parameter BASE_ADDR, default 11'h000, byte address of the first text word.
REQ-002 Parameter CHAR_COUNT, default 16, maximum number of words read per pass (1..31).
REQ-003 Parameter CIPHER_START, default 4, word index from which words are NOT-ciphered.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a read pass.
REQ-007 mem_addr  output  11  byte address to text data memory; word-aligned, step 4.
REQ-008 mem_data  input  32  word returned combinationally by the memory for mem_addr in the same cycle.
REQ-009 char_valid  output  1  decoded character available.
REQ-010 char_ready  input  1  downstream VGA character buffer accepts the character.
REQ-011 char_data  output  8  decoded ASCII character.
REQ-012 char_index  output  5  position of char_data within the pass, starting at 0.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at the end of a pass.
REQ-015 fmt_err  output  1  sticky: a word failed the format check during the current pass.

Function
REQ-016 The FSM SHALL have states IDLE, READ, OFFER and FINISH.
REQ-017 IDLE: start=1 -> READ, index cleared to 0, mem_addr set to BASE_ADDR, fmt_err cleared; start SHALL be ignored in all other states.
REQ-018 READ: lasts exactly one cycle; mem_data is sampled at its end.
REQ-019 If the sampled word is 32'h0, the pass terminates: no character is emitted and the next state is FINISH.
REQ-020 If index < CIPHER_START: plaintext word; char_data = mem_data[7:0]; format is valid only when mem_data[31:8] == 0.
REQ-021 If index >= CIPHER_START: ciphered word; char_data = ~mem_data[7:0]; format is valid only when mem_data[31:8] == 24'hFFFFFF.
REQ-022 On a format violation, char_data SHALL be 8'h3F ('?'), fmt_err SHALL set, and the character SHALL still be emitted.
REQ-023 READ with a non-zero word -> OFFER; char_valid rises on the cycle after READ (2 cycles after start is sampled).
REQ-024 OFFER: char_valid, char_data and char_index SHALL hold stable until a cycle with char_ready=1.
REQ-025 The handshake completes on a clock edge where char_valid and char_ready are both 1; char_valid falls on the next cycle.
REQ-026 On handshake: if index == CHAR_COUNT-1 -> FINISH; otherwise index+1, mem_addr+4 and -> READ.
REQ-027 mem_addr arithmetic SHALL be 11-bit modulo 2048 (0x7FC + 4 -> 0x000).
REQ-028 char_ready while char_valid=0 SHALL have no effect.
REQ-029 FINISH: done=1 for exactly one cycle, then -> IDLE; a start in the FINISH cycle is ignored.
REQ-030 char_valid SHALL never be high outside OFFER; done SHALL never be high outside FINISH.
REQ-031 fmt_err SHALL hold its value through FINISH and IDLE until the next accepted start.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, mem_addr=BASE_ADDR, char_valid=0, char_data=0, char_index=0, busy=0, done=0, fmt_err=0.
REQ-033 Reset asserted mid-pass (including during OFFER) SHALL abandon the pass, with no done pulse and no further char_valid.
REQ-034 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-035 Default memory image (H,O,L,A, ~O,~L,~A,~&, then 0), char_ready tied 1, start pulse -> chars 0x48,0x4F,0x4C,0x41,0x4F,0x4C,0x41,0x26 at indices 0..7; word at 0x020 terminates; done pulses once; fmt_err=0.
REQ-036 Same image, char_ready held 0 for 5 cycles during index 2 -> char_valid=1 with char_data=0x4C stable throughout; mem_addr stays 0x008 until handshake.
REQ-037 Word 32'h0000_0141 at index 1 -> char_data=0x3F, fmt_err=1; pass continues and fmt_err stays 1 after done until the next start.
REQ-038 CHAR_COUNT=3, no zero words -> exactly 3 characters, then done; mem_addr last read is BASE_ADDR+8.
REQ-039 reset asserted while in OFFER at index 5 -> outputs zero asynchronously; no done; a new start restarts at BASE_ADDR with index 0.
REQ-040 BASE_ADDR=11'h7FC, CHAR_COUNT=2 -> addresses read are 0x7FC then 0x000; start pulses during busy are ignored.

Source files
------------

// File: rtl/vga_text_reader.sv
// Reads a pass of text words from memory, decodes each into an ASCII character
// (plain or NOT-ciphered) and offers it downstream over a valid/ready handshake.
module vga_text_reader #(
    parameter logic [10:0] BASE_ADDR    = 11'h000,
    parameter int          CHAR_COUNT   = 16,
    parameter int          CIPHER_START = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [10:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_data,
    output logic [4:0]  char_index,
    output logic        busy,
    output logic        done,
    output logic        fmt_err
);
    typedef enum logic [1:0] {IDLE, READ, OFFER, FINISH} state_t;

    localparam logic [4:0] LAST_INDEX  = 5'(CHAR_COUNT - 1);
    // A threshold beyond the 5-bit index range means every word is plaintext.
    localparam logic [5:0] CIPHER_FROM = (CIPHER_START > 31) ? 6'd32 : 6'(CIPHER_START);

    state_t      state_reg, state_next;
    logic [4:0]  index_reg, index_next;
    logic [10:0] addr_reg, addr_next;
    logic [7:0]  char_reg, char_next;
    logic        fmt_reg, fmt_next;

    logic        is_plain;
    logic        word_ok;
    logic [7:0]  decoded;

    always_comb begin
        is_plain = ({1'b0, index_reg} < CIPHER_FROM);
        word_ok  = is_plain ? (mem_data[31:8] == 24'h000000)
                            : (mem_data[31:8] == 24'hFFFFFF);
        decoded  = is_plain ? mem_data[7:0] : ~mem_data[7:0];
        if (!word_ok) begin
            decoded = 8'h3F;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            index_reg <= 5'd0;
            addr_reg  <= BASE_ADDR;
            char_reg  <= 8'h00;
            fmt_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            addr_reg  <= addr_next;
            char_reg  <= char_next;
            fmt_reg   <= fmt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        addr_next  = addr_reg;
        char_next  = char_reg;
        fmt_next   = fmt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                    index_next = 5'd0;
                    addr_next  = BASE_ADDR;
                    fmt_next   = 1'b0;
                end
            end
            READ: begin
                // A zero word is the end-of-text marker and is never emitted.
                if (mem_data == 32'h0) begin
                    state_next = FINISH;
                end else begin
                    state_next = OFFER;
                    char_next  = decoded;
                    if (!word_ok) begin
                        fmt_next = 1'b1;
                    end
                end
            end
            OFFER: begin
                if (char_ready) begin
                    if (index_reg == LAST_INDEX) begin
                        state_next = FINISH;
                    end else begin
                        state_next = READ;
                        index_next = index_reg + 5'd1;
                        addr_next  = addr_reg + 11'd4;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_addr   = addr_reg;
    assign char_valid = (state_reg == OFFER);
    assign char_data  = char_reg;
    assign char_index = index_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == FINISH);
    assign fmt_err    = fmt_reg;
endmodule
